// File: rtl/channel_arbiter.sv
// channel_arbiter
// Round-robin arbiter that shares one blocking channel input among N_REQ
// producers. A granted producer keeps the channel for up to MAX_BURST
// consecutive words. Channel-side outputs are combinational functions of the
// registered arbitration state, so a word is presented with zero latency.
module channel_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 2,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       ch_data,
    output logic                   ch_valid,
    input  logic                   ch_is_full,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   locked
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SUM_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [SUM_W-1:0] N_REQ_S  = SUM_W'(N_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] words [N_REQ];
    logic [SUM_W-1:0] scan_idx;
    logic [IDX_W-1:0] sel;
    logic             any_valid;

    logic [N_REQ-1:0] ready_c;
    logic [WIDTH-1:0] data_c;
    logic             valid_c;
    logic [IDX_W-1:0] gidx_c;
    logic             xfer;

    // Index successor that wraps correctly for non-power-of-2 N_REQ.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX)
            return '0;
        return idx + IDX_W'(1);
    endfunction

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            words[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Round-robin scan: walk backwards so the first valid index at or after rr_ptr wins.
    always_comb begin
        sel       = rr_ptr;
        scan_idx  = '0;
        any_valid = |req_valid;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = SUM_W'(rr_ptr) + SUM_W'(k);
            if (scan_idx >= N_REQ_S)
                scan_idx = scan_idx - N_REQ_S;
            if (req_valid[scan_idx[IDX_W-1:0]])
                sel = scan_idx[IDX_W-1:0];
        end
    end

    // Channel-side view of the current grant, before reset masking.
    always_comb begin
        valid_c = 1'b0;
        data_c  = '0;
        ready_c = '0;
        gidx_c  = rr_ptr;
        if (state == IDLE) begin
            if (any_valid) begin
                valid_c      = 1'b1;
                data_c       = words[sel];
                gidx_c       = sel;
                ready_c[sel] = !ch_is_full;
            end
        end else begin
            gidx_c = owner;
            if (req_valid[owner]) begin
                valid_c        = 1'b1;
                data_c         = words[owner];
                ready_c[owner] = !ch_is_full;
            end
        end
    end

    assign xfer = valid_c && !ch_is_full;

    // Reset forces every output quiet so nothing transfers in a reset cycle.
    always_comb begin
        ch_valid  = reset ? valid_c : 1'b0;
        ch_data   = reset ? data_c : '0;
        req_ready = reset ? ready_c : '0;
        grant_idx = reset ? gidx_c : '0;
        locked    = reset ? (state == LOCKED) : 1'b0;
    end

    // Arbitration state machine: burst lock, burst counting and pointer advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr <= wrap_inc(sel);
                        end else begin
                            state <= LOCKED;
                            owner <= sel;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                LOCKED: begin
                    if (!req_valid[owner]) begin
                        // Owner went away: give up the lock after a one-cycle bubble.
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                        cnt    <= '0;
                    end else if (xfer) begin
                        if (cnt == CNT_LAST) begin
                            state  <= IDLE;
                            rr_ptr <= wrap_inc(owner);
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
